// File: rtl/id_ex_pkg.sv
// Shared widths and state encoding for the ID/EX elastic pipeline register.
package id_ex_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int WB_W_DEF   = 2;
  localparam int MEM_W_DEF  = 3;
  localparam int EX_W_DEF   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/id_ex_elastic.sv
// ID/EX pipeline register with a two-slot skid buffer so Ready_o never
// depends combinationally on Ready_i.
module id_ex_elastic
  import id_ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int MEM_W  = MEM_W_DEF,
  parameter int EX_W   = EX_W_DEF
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              Flush_i,
  input  logic              Valid_i,
  output logic              Ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [MEM_W-1:0]  MEM_i,
  input  logic [EX_W-1:0]   EX_i,
  input  logic [DATA_W-1:0] Data1_i,
  input  logic [DATA_W-1:0] Data2_i,
  input  logic [DATA_W-1:0] Immediate_i,
  input  logic [REG_W-1:0]  RegRs_i,
  input  logic [REG_W-1:0]  RegRt_i,
  input  logic [REG_W-1:0]  RegRd_i,
  output logic              Valid_o,
  input  logic              Ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [MEM_W-1:0]  MEM_o,
  output logic [EX_W-1:0]   EX_o,
  output logic [DATA_W-1:0] Data1_o,
  output logic [DATA_W-1:0] Data2_o,
  output logic [DATA_W-1:0] Immediate_o,
  output logic [REG_W-1:0]  RegRs_o,
  output logic [REG_W-1:0]  RegRt_o,
  output logic [REG_W-1:0]  RegRd_o
);

  localparam int PAY_W = WB_W + MEM_W + EX_W + 3 * DATA_W + 3 * REG_W;

  state_e             state_q, state_d;
  logic [PAY_W-1:0]   main_q, main_d;
  logic [PAY_W-1:0]   skid_q, skid_d;
  logic [PAY_W-1:0]   in_pay;
  logic               accept;
  logic               deliver;

  assign in_pay  = {WB_i, MEM_i, EX_i, Data1_i, Data2_i, Immediate_i,
                    RegRs_i, RegRt_i, RegRd_i};
  assign accept  = Valid_i & Ready_o;
  assign deliver = Valid_o & Ready_i;

  // SKID is deliberately left out of reset: it is only read after being loaded.
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
    skid_q <= skid_d;
  end

  // Flush leaves MAIN untouched so the data outputs keep their last value.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_pay;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_d = in_pay;
          end else if (accept) begin
            skid_d  = in_pay;
            state_d = FULL;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control fields become a bubble whenever nothing valid is presented.
  always_comb begin
    Ready_o = (state_q != FULL);
    Valid_o = (state_q != EMPTY);
    {WB_o, MEM_o, EX_o, Data1_o, Data2_o, Immediate_o,
     RegRs_o, RegRt_o, RegRd_o} = main_q;
    if (!Valid_o) begin
      WB_o  = '0;
      MEM_o = '0;
      EX_o  = '0;
    end
  end

endmodule

// File: tb/tb_id_ex_elastic.sv
// Directed and scoreboarded checks of the ID/EX elastic register: handshake,
// skid behaviour, flush, reset priority and bubble masking.
module tb_id_ex_elastic;

  logic        Clock_i;
  logic        Reset_i;
  logic        Flush_i;
  logic        Valid_i;
  logic        Ready_o;
  logic [1:0]  WB_i;
  logic [2:0]  MEM_i;
  logic [3:0]  EX_i;
  logic [31:0] Data1_i;
  logic [31:0] Data2_i;
  logic [31:0] Immediate_i;
  logic [4:0]  RegRs_i;
  logic [4:0]  RegRt_i;
  logic [4:0]  RegRd_i;
  logic        Valid_o;
  logic        Ready_i;
  logic [1:0]  WB_o;
  logic [2:0]  MEM_o;
  logic [3:0]  EX_o;
  logic [31:0] Data1_o;
  logic [31:0] Data2_o;
  logic [31:0] Immediate_o;
  logic [4:0]  RegRs_o;
  logic [4:0]  RegRt_o;
  logic [4:0]  RegRd_o;

  int checks;
  int errors;

  id_ex_elastic dut (
    .Clock_i     (Clock_i),
    .Reset_i     (Reset_i),
    .Flush_i     (Flush_i),
    .Valid_i     (Valid_i),
    .Ready_o     (Ready_o),
    .WB_i        (WB_i),
    .MEM_i       (MEM_i),
    .EX_i        (EX_i),
    .Data1_i     (Data1_i),
    .Data2_i     (Data2_i),
    .Immediate_i (Immediate_i),
    .RegRs_i     (RegRs_i),
    .RegRt_i     (RegRt_i),
    .RegRd_i     (RegRd_i),
    .Valid_o     (Valid_o),
    .Ready_i     (Ready_i),
    .WB_o        (WB_o),
    .MEM_o       (MEM_o),
    .EX_o        (EX_o),
    .Data1_o     (Data1_o),
    .Data2_o     (Data2_o),
    .Immediate_o (Immediate_o),
    .RegRs_o     (RegRs_o),
    .RegRt_o     (RegRt_o),
    .RegRd_o     (RegRd_o)
  );

  initial Clock_i = 1'b0;
  always #5 Clock_i = ~Clock_i;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge Clock_i);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [31:0] d, input logic [3:0] ex);
    Valid_i     = v;
    Data1_i     = d;
    Data2_i     = ~d;
    Immediate_i = d ^ 32'hA5A5_0000;
    WB_i        = d[1:0];
    MEM_i       = d[4:2];
    EX_i        = ex;
    RegRs_i     = d[4:0];
    RegRt_i     = d[9:5];
    RegRd_i     = ~d[4:0];
  endtask

  task automatic drain();
    Flush_i = 1'b0;
    Reset_i = 1'b0;
    Ready_i = 1'b1;
    set_beat(1'b0, 32'h0, 4'h0);
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    Reset_i = 1'b1;
    Flush_i = 1'b0;
    Ready_i = 1'b0;
    set_beat(1'b0, 32'h0, 4'h0);
    step();
    step();
    Reset_i = 1'b0;
    checks++;
    if (Valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", Valid_o); end
    checks++;
    if (Ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", Ready_o); end
    checks++;
    if (Data1_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_data1: got %h expected 0", Data1_o); end
    checks++;
    if (Immediate_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_imm: got %h expected 0", Immediate_o); end
    checks++;
    if ({WB_o, MEM_o, EX_o, RegRd_o} !== 14'h0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %h expected 0", {WB_o, MEM_o, EX_o, RegRd_o});
    end
  endtask

  task automatic test_single();
    drain();
    Ready_i = 1'b1;
    set_beat(1'b1, 32'h11, 4'h6);
    step();
    set_beat(1'b0, 32'h0, 4'h0);
    checks++;
    if (Valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", Valid_o); end
    checks++;
    if (Ready_o !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", Ready_o); end
    checks++;
    if (Data1_o !== 32'h11) begin errors++; $display("[TB] FAIL single_data1: got %h expected 11", Data1_o); end
    checks++;
    if (Data2_o !== 32'hFFFF_FFEE) begin errors++; $display("[TB] FAIL single_data2: got %h expected ffffffee", Data2_o); end
    checks++;
    if (Immediate_o !== 32'hA5A5_0011) begin errors++; $display("[TB] FAIL single_imm: got %h expected a5a50011", Immediate_o); end
    checks++;
    if ({WB_o, MEM_o, EX_o} !== {2'b01, 3'b100, 4'h6}) begin
      errors++; $display("[TB] FAIL single_ctrl: got %h expected %h", {WB_o, MEM_o, EX_o}, {2'b01, 3'b100, 4'h6});
    end
    checks++;
    if ({RegRs_o, RegRt_o, RegRd_o} !== {5'h11, 5'h00, 5'h0E}) begin
      errors++; $display("[TB] FAIL single_regs: got %h expected %h", {RegRs_o, RegRt_o, RegRd_o}, {5'h11, 5'h00, 5'h0E});
    end
    step();
    checks++;
    if (Valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid: got %b expected 0", Valid_o); end
    checks++;
    if ({WB_o, MEM_o, EX_o} !== 9'h0) begin errors++; $display("[TB] FAIL bubble_ctrl: got %h expected 0", {WB_o, MEM_o, EX_o}); end
    checks++;
    if (Data1_o !== 32'h11) begin errors++; $display("[TB] FAIL bubble_hold: got %h expected 11", Data1_o); end
  endtask

  task automatic test_skid_stream();
    drain();
    Ready_i = 1'b1;
    set_beat(1'b1, 32'h1, 4'h1);
    step();
    Ready_i = 1'b0;
    set_beat(1'b1, 32'h2, 4'h2);
    step();
    checks++;
    if (Ready_o !== 1'b0) begin errors++; $display("[TB] FAIL skid_ready_low: got %b expected 0", Ready_o); end
    checks++;
    if (Data1_o !== 32'h1) begin errors++; $display("[TB] FAIL skid_head1: got %h expected 1", Data1_o); end
    set_beat(1'b1, 32'h3, 4'h3);
    step();
    checks++;
    if (Data1_o !== 32'h1 || Valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL skid_stall: got %h/%b expected 1/1", Data1_o, Valid_o);
    end
    Ready_i = 1'b1;
    step();
    checks++;
    if (Data1_o !== 32'h2 || Ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL skid_second: got %h/%b expected 2/1", Data1_o, Ready_o);
    end
    step();
    set_beat(1'b0, 32'h0, 4'h0);
    checks++;
    if (Data1_o !== 32'h3 || EX_o !== 4'h3) begin
      errors++; $display("[TB] FAIL skid_third: got %h/%h expected 3/3", Data1_o, EX_o);
    end
    step();
    checks++;
    if (Valid_o !== 1'b0) begin errors++; $display("[TB] FAIL skid_drained: got %b expected 0", Valid_o); end
  endtask

  task automatic test_back_to_back();
    drain();
    Ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b1, 32'h40 + i, 4'(i + 8));
      step();
      checks++;
      if (Valid_o !== 1'b1 || Ready_o !== 1'b1 || Data1_o !== 32'h40 + i) begin
        errors++; $display("[TB] FAIL b2b_%0d: got %b/%b/%h expected 1/1/%h", i, Valid_o, Ready_o, Data1_o, 32'h40 + i);
      end
    end
    set_beat(1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_flush_full();
    drain();
    Ready_i = 1'b0;
    set_beat(1'b1, 32'hA, 4'h5);
    step();
    set_beat(1'b1, 32'hB, 4'h7);
    step();
    checks++;
    if (Ready_o !== 1'b0) begin errors++; $display("[TB] FAIL flushfull_setup: got %b expected 0", Ready_o); end
    Flush_i = 1'b1;
    step();
    Flush_i = 1'b0;
    set_beat(1'b0, 32'h0, 4'h0);
    checks++;
    if (Valid_o !== 1'b0 || Ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL flushfull_hs: got %b/%b expected 0/1", Valid_o, Ready_o);
    end
    checks++;
    if ({WB_o, MEM_o, EX_o} !== 9'h0) begin errors++; $display("[TB] FAIL flushfull_ctrl: got %h expected 0", {WB_o, MEM_o, EX_o}); end
    Ready_i = 1'b1;
    step();
    checks++;
    if (Valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flushfull_noleak: got %b expected 0", Valid_o); end
  endtask

  task automatic test_flush_busy();
    drain();
    Ready_i = 1'b0;
    set_beat(1'b1, 32'h21, 4'h1);
    step();
    set_beat(1'b1, 32'h22, 4'h2);
    Flush_i = 1'b1;
    step();
    Flush_i = 1'b0;
    set_beat(1'b0, 32'h0, 4'h0);
    checks++;
    if (Valid_o !== 1'b0 || Ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL flushbusy_hs: got %b/%b expected 0/1", Valid_o, Ready_o);
    end
    checks++;
    if (Data1_o !== 32'h21) begin errors++; $display("[TB] FAIL flushbusy_hold: got %h expected 21", Data1_o); end
    Ready_i = 1'b1;
    step();
    checks++;
    if (Valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flushbusy_drop: got %b expected 0", Valid_o); end
  endtask

  task automatic test_reset_full();
    drain();
    Ready_i = 1'b0;
    set_beat(1'b1, 32'h31, 4'h3);
    step();
    set_beat(1'b1, 32'h32, 4'h4);
    step();
    Reset_i = 1'b1;
    Flush_i = 1'b1;
    Ready_i = 1'b1;
    step();
    Reset_i = 1'b0;
    Flush_i = 1'b0;
    set_beat(1'b0, 32'h0, 4'h0);
    checks++;
    if (Valid_o !== 1'b0 || Ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rstfull_hs: got %b/%b expected 0/1", Valid_o, Ready_o);
    end
    checks++;
    if (Data1_o !== 32'h0 || Immediate_o !== 32'h0 || EX_o !== 4'h0) begin
      errors++; $display("[TB] FAIL rstfull_out: got %h/%h/%h expected 0/0/0", Data1_o, Immediate_o, EX_o);
    end
    set_beat(1'b1, 32'h55, 4'hA);
    step();
    set_beat(1'b0, 32'h0, 4'h0);
    checks++;
    if (Valid_o !== 1'b1 || EX_o !== 4'hA || Data1_o !== 32'h55) begin
      errors++; $display("[TB] FAIL rstfull_after: got %b/%h/%h expected 1/a/55", Valid_o, EX_o, Data1_o);
    end
    step();
  endtask

  // Depth-2 FIFO model: the DUT must behave as an ordered two-entry queue.
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] next_d;
    logic        v;
    logic        r;
    logic        acc;
    logic        dlv;
    drain();
    next_d = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 55);
      set_beat(v, next_d, next_d[3:0]);
      Ready_i = r;
      checks++;
      if (Ready_o !== (q.size() < 2) || Valid_o !== (q.size() > 0)) begin
        errors++; $display("[TB] FAIL rand_hs c%0d: got %b/%b expected %b/%b", c, Ready_o, Valid_o, q.size() < 2, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (Data1_o !== q[0] || EX_o !== q[0][3:0]) begin
          errors++; $display("[TB] FAIL rand_data c%0d: got %h/%h expected %h", c, Data1_o, EX_o, q[0]);
        end
      end else begin
        checks++;
        if (EX_o !== 4'h0) begin errors++; $display("[TB] FAIL rand_bubble c%0d: got %h expected 0", c, EX_o); end
      end
      acc = v && (q.size() < 2);
      dlv = r && (q.size() > 0);
      if (dlv) void'(q.pop_front());
      if (acc) begin
        q.push_back(next_d);
        next_d = next_d + 32'h1;
      end
      step();
    end
    set_beat(1'b0, 32'h0, 4'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset_i = 1'b1;
    Flush_i = 1'b0;
    Ready_i = 1'b0;
    set_beat(1'b0, 32'h0, 4'h0);
    #2;
    test_reset();
    test_single();
    test_skid_stream();
    test_back_to_back();
    test_flush_full();
    test_flush_busy();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_elastic.md
ID_EX_ELASTIC -- requirements
Module: id_ex_elastic

Interface
REQ-001 Parameter DATA_W, default 32, width of Data1/Data2/Immediate.
REQ-002 Parameter REG_W, default 5, width of RegRs/RegRt/RegRd.
REQ-003 Parameters WB_W, MEM_W, EX_W, defaults 2, 3, 4, widths of the WB/MEM/EX control fields.
REQ-004 Clock_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 Reset_i  input  1  reset; synchronous and active-high.
REQ-006 Flush_i  input  1  discard all held entries (branch/hazard squash).
REQ-007 Valid_i  input  1  ID stage presents a valid instruction.
REQ-008 Ready_o  output  1  stage accepts an instruction this cycle.
REQ-009 WB_i, MEM_i, EX_i  input  WB_W/MEM_W/EX_W  control fields from decode.
REQ-010 Data1_i, Data2_i, Immediate_i  input  DATA_W  operands and sign-extended immediate.
REQ-011 RegRs_i, RegRt_i, RegRd_i  input  REG_W  register specifiers.
REQ-012 Valid_o  output  1  EX stage is presented a valid instruction.
REQ-013 Ready_i  input  1  EX stage accepts the presented instruction.
REQ-014 WB_o, MEM_o, EX_o, Data1_o, Data2_o, Immediate_o, RegRs_o, RegRt_o, RegRd_o  output  as inputs  registered payload.

Function
REQ-015 Accept = Valid_i & Ready_o; Deliver = Valid_o & Ready_i.
REQ-016 Storage SHALL be two payload slots, MAIN (drives outputs) and SKID, tracked by states EMPTY, BUSY (MAIN full), FULL (MAIN and SKID full).
REQ-017 EMPTY: Accept -> load MAIN, go BUSY; else stay.
REQ-018 BUSY: Accept & Deliver -> load MAIN, stay; Accept only -> load SKID, go FULL; Deliver only -> go EMPTY; neither -> stay.
REQ-019 FULL: Deliver -> copy SKID to MAIN, go BUSY; else stay.
REQ-020 Ready_o SHALL be 1 in EMPTY and BUSY, 0 in FULL, driven from state only (no combinational Ready_i -> Ready_o path).
REQ-021 Valid_o SHALL be 1 in BUSY and FULL, 0 in EMPTY.
REQ-022 Latency EMPTY -> Valid_o SHALL be one cycle; sustained throughput one instruction per cycle while Ready_i=1.
REQ-023 Order SHALL be preserved; no instruction is duplicated or dropped except by Flush_i.
REQ-024 Flush_i=1 SHALL force state EMPTY next cycle regardless of Valid_i/Ready_i; the beat offered in the flush cycle is dropped.
REQ-025 WB_o, MEM_o, EX_o SHALL read 0 whenever Valid_o=0 (bubble semantics toward MEM/WB).
REQ-026 Data, immediate and register-specifier outputs SHALL hold their last value when Valid_o=0.
REQ-027 Payload SHALL be stored bit-exact; no width conversion or arithmetic.

Reset
REQ-028 Reset_i=1 at a rising edge SHALL set state EMPTY and all outputs 0 (Ready_o=1 after reset).
REQ-029 Reset SHALL take priority over Flush_i and any transfer, including mid-FULL.
REQ-030 SKID payload is not required to be reset.

Structure
REQ-031 Package id_ex_pkg SHALL hold default width constants and the EMPTY/BUSY/FULL state type.
REQ-032 Single module, no sub-modules; payload packed into one vector per slot.

Verification
REQ-033 Reset, Valid_i=1, Data1_i=0x11, Ready_i=1 -> next cycle Valid_o=1, Data1_o=0x11, Ready_o=1.
REQ-034 Stream 0x1,0x2,0x3 with Ready_i=0 from cycle 2 -> Ready_o drops after 0x2 stored in SKID; releasing Ready_i yields 0x1,0x2,0x3 in order, none lost.
REQ-035 FULL state, Flush_i=1 -> next cycle Valid_o=0, WB_o=MEM_o=EX_o=0, Ready_o=1.
REQ-036 BUSY, Valid_i=1 and Flush_i=1 same cycle -> offered beat dropped, state EMPTY.
REQ-037 FULL, Reset_i=1 -> all outputs 0 next cycle; subsequent EX_i=0xA accepted and delivered with EX_o=0xA.
REQ-038 Random Valid_i/Ready_i, 10k cycles, scoreboard -> in-order delivery, Ready_o never 1 in FULL.
